// File: rtl/bram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_access_arbiter_pkg
// Description : Shared constants for the image BRAM access path: owner
//               encoding, default BRAM field widths and the arbiter state
//               type (state encoding equals the owner encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package bram_access_arbiter_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_CH_W   = 2;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P0   = 2'd1;
    localparam logic [1:0] OWN_P1   = 2'd2;

    // The state is the last grantee.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bram_access_arbiter_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : read_tag_pipe
// Description : DEPTH-stage shift register of {valid, port} tags that tracks
//               outstanding BRAM reads. A tag pushed with a read grant
//               reaches the last stage DEPTH cycles later.
// Ports       : clk, rst (async, active-low)
//               push       - a read was granted this cycle
//               port_in    - requesting port of that read (0/1)
//               exit_valid - tag in the second-to-last stage (data is
//                            on bram_data_out this cycle)
//               out_valid  - tag in the last stage
//               out_port   - port of the last-stage tag
// Revision    : 1.0 - initial release
// ============================================================================
module read_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic port_in,
    output logic exit_valid,
    output logic out_valid,
    output logic out_port
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_port;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_port  <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], push};
            r_port  <= {r_port[DEPTH-2:0], port_in};
        end
    end

    assign exit_valid = r_valid[DEPTH-2];
    assign out_valid  = r_valid[DEPTH-1];
    assign out_port   = r_port[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_access_arbiter
// Description : Shares the single-port image BRAM between port 0 (SPI
//               transfer controller) and port 1 (image processing engine).
//               Round-robin arbitration with optional burst locking capped
//               at MAX_BURST consecutive grants while the other port waits.
//               The winning access is registered onto the BRAM pins; read
//               data returns on rdata with a per-port valid pulse
//               READ_LAT+1 cycles after the grant.
// Ports       : clk, rst (async, active-low)
//               req/we/lock/addr/ch/wdata 0|1 - requester inputs
//               gnt0/gnt1       - combinational grant (transfer = req & gnt)
//               rvalid0/rvalid1 - read data valid pulse, rdata shared
//               owner           - last grantee (0 none, 1 port0, 2 port1)
//               bram_*          - registered BRAM pins, bram_data_out input
// Revision    : 1.0 - initial release
// ============================================================================
module bram_access_arbiter
    import bram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CH_W      = DEF_CH_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [CH_W-1:0]   ch0,
    input  logic [CH_W-1:0]   ch1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        owner,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [CH_W-1:0]   bram_channel,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_data_in,
    input  logic [DATA_W-1:0] bram_data_out
);

    localparam int                 c_CNT_W = $clog2(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_CAP   = c_CNT_W'(MAX_BURST - 1);

    arb_state_t         r_state, w_state_nxt;
    logic               r_lock, w_lock_nxt;
    logic [c_CNT_W-1:0] r_burst_cnt, w_cnt_nxt;

    logic w_hold0, w_hold1;
    logic w_sel0, w_sel1, w_xfer, w_sel_we;
    logic w_exit_valid, w_out_valid, w_out_port;

    logic [ADDR_W-1:0] r_bram_addr;
    logic [CH_W-1:0]   r_bram_channel;
    logic              r_bram_we;
    logic [DATA_W-1:0] r_bram_data_in;
    logic [DATA_W-1:0] r_rdata;

    // The owner may keep the BRAM only if it asked for lock on its previous
    // grant; once the cap is hit it must yield if the other port is waiting.
    assign w_hold0 = (r_state == ST_OWN0) && req0 && r_lock &&
                     ((r_burst_cnt < c_CAP) || !req1);
    assign w_hold1 = (r_state == ST_OWN1) && req1 && r_lock &&
                     ((r_burst_cnt < c_CAP) || !req0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_lock      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock      <= w_lock_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_sel0      = 1'b0;
        w_sel1      = 1'b0;
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock;
        w_cnt_nxt   = r_burst_cnt;

        if (w_hold0) begin
            w_sel0 = 1'b1;
        end else if (w_hold1) begin
            w_sel1 = 1'b1;
        end else if (req0 && req1) begin
            // Contention: serve whoever was not served last (IDLE favours 0).
            if (r_state == ST_OWN0) begin
                w_sel1 = 1'b1;
            end else begin
                w_sel0 = 1'b1;
            end
        end else if (req0) begin
            w_sel0 = 1'b1;
        end else if (req1) begin
            w_sel1 = 1'b1;
        end

        if (w_sel0 || w_sel1) begin
            w_state_nxt = w_sel1 ? ST_OWN1 : ST_OWN0;
            w_lock_nxt  = w_sel1 ? lock1 : lock0;
            // Restart on an owner switch, and also when an uncontested
            // owner runs past the cap so the counter never saturates.
            if ((w_state_nxt != r_state) || (r_burst_cnt >= c_CAP)) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_burst_cnt + c_CNT_W'(1);
            end
        end
    end

    assign w_xfer   = w_sel0 | w_sel1;
    assign w_sel_we = w_sel1 ? we1 : we0;

    // Grants are forced low while reset is asserted.
    assign gnt0 = w_sel0 & rst;
    assign gnt1 = w_sel1 & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bram_addr    <= '0;
            r_bram_channel <= '0;
            r_bram_we      <= 1'b0;
            r_bram_data_in <= '0;
            r_rdata        <= '0;
        end else begin
            r_bram_we <= w_xfer & w_sel_we;
            if (w_xfer) begin
                r_bram_addr    <= w_sel1 ? addr1  : addr0;
                r_bram_channel <= w_sel1 ? ch1    : ch0;
                r_bram_data_in <= w_sel1 ? wdata1 : wdata0;
            end
            if (w_exit_valid) begin
                r_rdata <= bram_data_out;
            end
        end
    end

    read_tag_pipe #(
        .DEPTH (READ_LAT + 1)
    ) u_read_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (w_xfer & ~w_sel_we),
        .port_in    (w_sel1),
        .exit_valid (w_exit_valid),
        .out_valid  (w_out_valid),
        .out_port   (w_out_port)
    );

    always_comb begin
        owner = OWN_NONE;
        case (r_state)
            ST_OWN0: owner = OWN_P0;
            ST_OWN1: owner = OWN_P1;
            default: owner = OWN_NONE;
        endcase
    end

    assign rvalid0      = w_out_valid & ~w_out_port;
    assign rvalid1      = w_out_valid &  w_out_port;
    assign rdata        = r_rdata;
    assign bram_addr    = r_bram_addr;
    assign bram_channel = r_bram_channel;
    assign bram_we      = r_bram_we;
    assign bram_data_in = r_bram_data_in;

endmodule
`default_nettype wire

// File: tb/tb_bram_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bram_access_arbiter
// Description : Directed self-checking bench for bram_access_arbiter. One
//               instance uses the default READ_LAT=1, a second uses
//               READ_LAT=3. Each has a small behavioural BRAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default-latency instance
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [16:0] addr0, addr1;
    logic [1:0]  ch0, ch1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0]  rdata;
    logic [1:0]  owner;
    logic [16:0] bram_addr;
    logic [1:0]  bram_channel;
    logic        bram_we;
    logic [7:0]  bram_data_in, bram_data_out;

    // READ_LAT=3 instance
    logic        t3_req0, t3_req1, t3_we0, t3_we1, t3_lock0, t3_lock1;
    logic [16:0] t3_addr0, t3_addr1;
    logic [1:0]  t3_ch0, t3_ch1;
    logic [7:0]  t3_wdata0, t3_wdata1;
    logic        t3_gnt0, t3_gnt1, t3_rvalid0, t3_rvalid1;
    logic [7:0]  t3_rdata;
    logic [1:0]  t3_owner;
    logic [16:0] t3_bram_addr;
    logic [1:0]  t3_bram_channel;
    logic        t3_bram_we;
    logic [7:0]  t3_bram_data_in, t3_bram_data_out;

    int total = 0;
    int bad   = 0;

    bram_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .ch0(ch0), .ch1(ch1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .owner(owner),
        .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
        .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
    );

    bram_access_arbiter #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0(t3_req0), .req1(t3_req1), .we0(t3_we0), .we1(t3_we1),
        .lock0(t3_lock0), .lock1(t3_lock1), .addr0(t3_addr0), .addr1(t3_addr1),
        .ch0(t3_ch0), .ch1(t3_ch1), .wdata0(t3_wdata0), .wdata1(t3_wdata1),
        .gnt0(t3_gnt0), .gnt1(t3_gnt1), .rvalid0(t3_rvalid0), .rvalid1(t3_rvalid1),
        .rdata(t3_rdata), .owner(t3_owner),
        .bram_addr(t3_bram_addr), .bram_channel(t3_bram_channel), .bram_we(t3_bram_we),
        .bram_data_in(t3_bram_data_in), .bram_data_out(t3_bram_data_out)
    );

    // BRAM models: the arbiter's pin register acts as the BRAM address
    // register, so READ_LAT=1 reads the array directly and READ_LAT=3 adds
    // two output stages.
    logic [7:0] mem  [0:1023];
    logic [7:0] mem3 [0:1023];
    logic [7:0] d3a, d3b;

    always @(posedge clk) begin
        if (bram_we) mem[{bram_channel, bram_addr[7:0]}] <= bram_data_in;
    end
    assign bram_data_out = mem[{bram_channel, bram_addr[7:0]}];

    always @(posedge clk) begin
        if (t3_bram_we) mem3[{t3_bram_channel, t3_bram_addr[7:0]}] <= t3_bram_data_in;
        d3a <= mem3[{t3_bram_channel, t3_bram_addr[7:0]}];
        d3b <= d3a;
    end
    assign t3_bram_data_out = d3b;

    task automatic drop_all();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        req0 = 1; req1 = 1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            bad++; $display("FAIL reset_gnt: gnt0=%0b gnt1=%0b expected 0 0", gnt0, gnt1);
        end
        total++;
        if ({rvalid0, rvalid1, bram_we} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes: rv0=%0b rv1=%0b we=%0b expected 0", rvalid0, rvalid1, bram_we);
        end
        total++;
        if (bram_addr !== 17'h0 || bram_channel !== 2'd0 || bram_data_in !== 8'h00 || rdata !== 8'h00) begin
            bad++; $display("FAIL reset_data: addr=%h ch=%0d din=%h rdata=%h expected 0", bram_addr, bram_channel, bram_data_in, rdata);
        end
        total++;
        if (owner !== 2'd0) begin
            bad++; $display("FAIL reset_owner: owner=%0d expected 0", owner);
        end
        drop_all();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 17'h00010; ch0 = 2'd1; wdata0 = 8'hA5;
        #1;
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++; $display("FAIL wr_gnt: gnt0=%0b gnt1=%0b expected 1 0", gnt0, gnt1);
        end
        @(negedge clk);
        drop_all();
        #1;
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 17'h00010 || bram_channel !== 2'd1 || bram_data_in !== 8'hA5) begin
            bad++; $display("FAIL wr_pins: we=%0b addr=%h ch=%0d din=%h expected 1 00010 1 a5", bram_we, bram_addr, bram_channel, bram_data_in);
        end
        total++;
        if (owner !== 2'd1) begin
            bad++; $display("FAIL wr_owner: owner=%0d expected 1", owner);
        end
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 17'h00010; ch1 = 2'd1;
        #1;
        total++;
        if (bram_we !== 1'b0 || bram_addr !== 17'h00010) begin
            bad++; $display("FAIL wr_pulse: we=%0b addr=%h expected 0 00010", bram_we, bram_addr);
        end
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            bad++; $display("FAIL rd_gnt: gnt0=%0b gnt1=%0b expected 0 1", gnt0, gnt1);
        end
        @(negedge clk);
        drop_all();
        #1;
        total++;
        if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            bad++; $display("FAIL rd_early: rv0=%0b rv1=%0b expected 0 0", rvalid0, rvalid1);
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 8'hA5) begin
            bad++; $display("FAIL rd_data: rv0=%0b rv1=%0b rdata=%h expected 0 1 a5", rvalid0, rvalid1, rdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid1 !== 1'b0) begin
            bad++; $display("FAIL rd_pulse: rv1=%0b expected 0", rvalid1);
        end
    endtask

    task automatic test_alternate();
        logic e0, e1;
        // prefill through port1 so port1 is the last served
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 17'h20; ch1 = 2'd0; wdata1 = 8'h11;
        @(negedge clk);
        addr1 = 17'h21; wdata1 = 8'h22;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req0 = (c < 6); req1 = (c < 6); we0 = 0; we1 = 0;
            addr0 = 17'h20; ch0 = 2'd0; addr1 = 17'h21; ch1 = 2'd0;
            #1;
            if (c < 6) begin
                e0 = (c % 2 == 0);
                total++;
                if (gnt0 !== e0 || gnt1 !== !e0) begin
                    bad++; $display("FAIL alt_gnt c=%0d: gnt0=%0b gnt1=%0b expected %0b %0b", c, gnt0, gnt1, e0, !e0);
                end
            end
            e0 = (c >= 2) && (c < 8) && (c % 2 == 0);
            e1 = (c >= 2) && (c < 8) && (c % 2 == 1);
            total++;
            if (rvalid0 !== e0 || rvalid1 !== e1) begin
                bad++; $display("FAIL alt_rvalid c=%0d: rv0=%0b rv1=%0b expected %0b %0b", c, rvalid0, rvalid1, e0, e1);
            end
            if (e0 || e1) begin
                total++;
                if (rdata !== (e0 ? 8'h11 : 8'h22)) begin
                    bad++; $display("FAIL alt_rdata c=%0d: rdata=%h expected %h", c, rdata, e0 ? 8'h11 : 8'h22);
                end
            end
        end
        drop_all();
    endtask

    task automatic test_burst_cap();
        int  p1;
        int  c;
        logic e1;
        // make port0 the current owner so port1's first grant is a switch
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 17'h30; ch0 = 2'd3; wdata0 = 8'h99;
        p1 = 0; c = 0;
        while (p1 < 40 && c < 60) begin
            @(negedge clk);
            req1 = 1; lock1 = 1; we1 = 0; addr1 = 17'h21; ch1 = 2'd0;
            req0 = (c >= 1); lock0 = 0; we0 = 1; addr0 = 17'h30; ch0 = 2'd3; wdata0 = 8'h99;
            #1;
            e1 = !(c == 16 || c == 33);
            total++;
            if (gnt1 !== e1 || gnt0 !== !e1) begin
                bad++; $display("FAIL burst_gnt c=%0d: gnt0=%0b gnt1=%0b expected %0b %0b", c, gnt0, gnt1, !e1, e1);
            end
            if (gnt1 === 1'b1) p1++;
            c++;
        end
        @(negedge clk);
        drop_all();
        total++;
        if (c != 42) begin
            bad++; $display("FAIL burst_len: cycles=%0d expected 42", c);
        end
    endtask

    task automatic test_lock_idle();
        logic       e0;
        logic [1:0] eo;
        repeat (3) @(negedge clk);
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) @(negedge clk);
            req0 = 1; lock0 = 1; we0 = 1; addr0 = 17'h40; ch0 = 2'd3; wdata0 = 8'(c);
            req1 = (c >= 20); lock1 = 0; we1 = 0; addr1 = 17'h21; ch1 = 2'd0;
            #1;
            e0 = (c < 32);
            total++;
            if (gnt0 !== e0 || gnt1 !== !e0) begin
                bad++; $display("FAIL lock_gnt c=%0d: gnt0=%0b gnt1=%0b expected %0b %0b", c, gnt0, gnt1, e0, !e0);
            end
            eo = (c == 0) ? 2'd2 : 2'd1;
            total++;
            if (owner !== eo) begin
                bad++; $display("FAIL lock_owner c=%0d: owner=%0d expected %0d", c, owner, eo);
            end
        end
        @(negedge clk);
        drop_all();
    endtask

    task automatic test_reset_mid();
        logic seen;
        repeat (4) @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 17'h20; ch0 = 2'd0;
        #1;
        total++;
        if (gnt0 !== 1'b1) begin
            bad++; $display("FAIL rstmid_gnt: gnt0=%0b expected 1", gnt0);
        end
        @(negedge clk);
        req0 = 0; req1 = 1; we1 = 0; addr1 = 17'h21; ch1 = 2'd0;
        rst = 0;
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, bram_we} !== 5'b0 || owner !== 2'd0) begin
            bad++; $display("FAIL rstmid_ctrl: gnt=%0b%0b rv=%0b%0b we=%0b owner=%0d expected 0", gnt0, gnt1, rvalid0, rvalid1, bram_we, owner);
        end
        total++;
        if (bram_addr !== 17'h0 || bram_channel !== 2'd0 || bram_data_in !== 8'h00 || rdata !== 8'h00) begin
            bad++; $display("FAIL rstmid_data: addr=%h ch=%0d din=%h rdata=%h expected 0", bram_addr, bram_channel, bram_data_in, rdata);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (rvalid0 === 1'b1 || rvalid1 === 1'b1) seen = 1;
        end
        @(negedge clk);
        rst = 1;
        #1;
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            bad++; $display("FAIL rstmid_first_gnt: gnt0=%0b gnt1=%0b expected 0 1", gnt0, gnt1);
        end
        @(negedge clk);
        req1 = 0;
        #1;
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) seen = 1;
        @(negedge clk);
        #1;
        if (rvalid0 === 1'b1) seen = 1;
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL rstmid_flush: stale rvalid=%0b expected 0", seen);
        end
        total++;
        if (rvalid1 !== 1'b1 || rdata !== 8'h22) begin
            bad++; $display("FAIL rstmid_read: rv1=%0b rdata=%h expected 1 22", rvalid1, rdata);
        end
    endtask

    task automatic test_read_latency3();
        logic       p, w, e0, e1;
        logic [16:0] a;
        logic [7:0] d, ed;
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            p = 0; w = 0; a = 17'h50; d = 8'h00;
            case (c)
                0: begin w = 1; a = 17'h50; d = 8'h5A; end
                1: begin w = 1; a = 17'h51; d = 8'hC3; end
                2: begin a = 17'h50; end
                3: begin a = 17'h51; end
                4: begin w = 1; a = 17'h50; d = 8'h77; end
                5: begin a = 17'h50; end
                6: begin p = 1; a = 17'h51; end
                default: ;
            endcase
            t3_req0 = (c < 7) && !p; t3_req1 = (c < 7) && p;
            t3_we0 = w; t3_we1 = w; t3_lock0 = 0; t3_lock1 = 0;
            t3_addr0 = a; t3_addr1 = a; t3_ch0 = 2'd2; t3_ch1 = 2'd2;
            t3_wdata0 = d; t3_wdata1 = d;
            #1;
            if (c < 7) begin
                total++;
                if (t3_gnt0 !== !p || t3_gnt1 !== p) begin
                    bad++; $display("FAIL rl3_gnt c=%0d: gnt0=%0b gnt1=%0b expected %0b %0b", c, t3_gnt0, t3_gnt1, !p, p);
                end
            end
            e0 = (c == 6) || (c == 7) || (c == 9);
            e1 = (c == 10);
            total++;
            if (t3_rvalid0 !== e0 || t3_rvalid1 !== e1) begin
                bad++; $display("FAIL rl3_rvalid c=%0d: rv0=%0b rv1=%0b expected %0b %0b", c, t3_rvalid0, t3_rvalid1, e0, e1);
            end
            if (e0 || e1) begin
                case (c)
                    6:       ed = 8'h5A;
                    7:       ed = 8'hC3;
                    9:       ed = 8'h77;
                    default: ed = 8'hC3;
                endcase
                total++;
                if (t3_rdata !== ed) begin
                    bad++; $display("FAIL rl3_rdata c=%0d: rdata=%h expected %h", c, t3_rdata, ed);
                end
            end
        end
        t3_req0 = 0; t3_req1 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        drop_all();
        addr0 = '0; addr1 = '0; ch0 = '0; ch1 = '0; wdata0 = '0; wdata1 = '0;
        t3_req0 = 0; t3_req1 = 0; t3_we0 = 0; t3_we1 = 0; t3_lock0 = 0; t3_lock1 = 0;
        t3_addr0 = '0; t3_addr1 = '0; t3_ch0 = '0; t3_ch1 = '0; t3_wdata0 = '0; t3_wdata1 = '0;
        test_reset();
        test_single_write();
        test_alternate();
        test_burst_cap();
        test_lock_idle();
        test_reset_mid();
        test_read_latency3();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
